// File: rtl/adrv9001_chan_seq.sv
// adrv9001_chan_seq: per-channel sequencer ordering chip enable and SSI datapath enable with settle delays.
// Optional define ADRV9001_CHAN_SEQ_LOCKSTEP_EN aligns ON entry of every channel waiting in EN_WAIT.
module adrv9001_chan_seq #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16
) (
  input  logic                    s_axi_aclk,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       req,
  input  logic [NUM_CH*CNT_W-1:0] en_dly,
  input  logic [NUM_CH*CNT_W-1:0] dis_dly,
  output logic [NUM_CH-1:0]       chan_en,
  output logic [NUM_CH-1:0]       ssi_en,
  output logic [NUM_CH-1:0]       busy,
  output logic [NUM_CH*2-1:0]     state,
  output logic [NUM_CH-1:0]       done
);

  typedef enum logic [1:0] {
    ST_OFF      = 2'b00,
    ST_EN_WAIT  = 2'b01,
    ST_ON       = 2'b10,
    ST_DIS_WAIT = 2'b11
  } state_t;

  // Handshake: req is a level; done is a one-cycle pulse when ON is reached or when DIS_WAIT returns to OFF.
  logic w_release;

`ifdef ADRV9001_CHAN_SEQ_LOCKSTEP_EN
  logic [NUM_CH-1:0] w_en_ready;
  assign w_release = &w_en_ready;
`else
  assign w_release = 1'b1;
`endif

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_chan_en;
    logic             r_ssi_en;
    logic             r_busy;
    logic             r_done;
    logic [CNT_W-1:0] w_en_dly;
    logic [CNT_W-1:0] w_dis_dly;

    assign w_en_dly  = en_dly[gi*CNT_W +: CNT_W];
    assign w_dis_dly = dis_dly[gi*CNT_W +: CNT_W];

`ifdef ADRV9001_CHAN_SEQ_LOCKSTEP_EN
    // A channel holds the group only while it still counts down; an aborting channel drops out at once.
    assign w_en_ready[gi] = (r_state != ST_EN_WAIT) || (r_cnt == '0) || !req[gi];
`endif

    always_ff @(posedge s_axi_aclk or posedge rst) begin
      if (rst) begin
        r_state   <= ST_OFF;
        r_cnt     <= '0;
        r_chan_en <= 1'b0;
        r_ssi_en  <= 1'b0;
        r_busy    <= 1'b0;
        r_done    <= 1'b0;
      end else begin
        r_done <= 1'b0;
        case (r_state)
          ST_OFF: begin
            if (req[gi]) begin
              r_state   <= ST_EN_WAIT;
              r_chan_en <= 1'b1;
              r_busy    <= 1'b1;
              r_cnt     <= w_en_dly;
            end
          end
          ST_EN_WAIT: begin
            if (!req[gi]) begin
              r_state   <= ST_OFF;
              r_chan_en <= 1'b0;
              r_busy    <= 1'b0;
            end else if (r_cnt == '0) begin
              if (w_release) begin
                r_state  <= ST_ON;
                r_ssi_en <= 1'b1;
                r_busy   <= 1'b0;
                r_done   <= 1'b1;
              end
            end else begin
              r_cnt <= r_cnt - CNT_W'(1);
            end
          end
          ST_ON: begin
            if (!req[gi]) begin
              r_state  <= ST_DIS_WAIT;
              r_ssi_en <= 1'b0;
              r_busy   <= 1'b1;
              r_cnt    <= w_dis_dly;
            end
          end
          ST_DIS_WAIT: begin
            // Disable always runs to completion so the chip enable never drops under a live datapath.
            if (r_cnt == '0) begin
              r_state   <= ST_OFF;
              r_chan_en <= 1'b0;
              r_busy    <= 1'b0;
              r_done    <= 1'b1;
            end else begin
              r_cnt <= r_cnt - CNT_W'(1);
            end
          end
          default: begin
            r_state <= ST_OFF;
          end
        endcase
      end
    end

    assign chan_en[gi]      = r_chan_en;
    assign ssi_en[gi]       = r_ssi_en;
    assign busy[gi]         = r_busy;
    assign done[gi]         = r_done;
    assign state[gi*2 +: 2] = r_state;
  end

endmodule

// File: tb/tb_adrv9001_chan_seq.sv
// tb_adrv9001_chan_seq: directed and randomized checks of adrv9001_chan_seq against a deadline-based model.
// Expectations follow ADRV9001_CHAN_SEQ_LOCKSTEP_EN when it is defined for the build.
module tb_adrv9001_chan_seq;
  localparam int NUM_CH = 4;
  localparam int CNT_W  = 16;
  localparam int W      = NUM_CH * 6;
  localparam int M_OFF  = 0;
  localparam int M_EN   = 1;
  localparam int M_ON   = 2;
  localparam int M_DIS  = 3;
`ifdef ADRV9001_CHAN_SEQ_LOCKSTEP_EN
  localparam bit LOCKSTEP = 1'b1;
`else
  localparam bit LOCKSTEP = 1'b0;
`endif

  logic                    clk = 1'b0;
  logic                    rst;
  logic [NUM_CH-1:0]       req;
  logic [NUM_CH*CNT_W-1:0] en_dly;
  logic [NUM_CH*CNT_W-1:0] dis_dly;
  logic [NUM_CH-1:0]       chan_en;
  logic [NUM_CH-1:0]       ssi_en;
  logic [NUM_CH-1:0]       busy;
  logic [NUM_CH*2-1:0]     state;
  logic [NUM_CH-1:0]       done;

  adrv9001_chan_seq #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
    .s_axi_aclk(clk),
    .rst(rst),
    .req(req),
    .en_dly(en_dly),
    .dis_dly(dis_dly),
    .chan_en(chan_en),
    .ssi_en(ssi_en),
    .busy(busy),
    .state(state),
    .done(done)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_checks = 0;
  int n_errors = 0;
  logic [W-1:0] exp_q[$];

  // Reference model: each channel is a mode plus the edge index at which its wait ends.
  int        m_mode[NUM_CH];
  longint    m_t[NUM_CH];
  longint    m_cyc;
  logic [NUM_CH-1:0] m_done;

  function automatic longint get_en(int ch);
    return longint'(en_dly[ch*CNT_W +: CNT_W]);
  endfunction

  function automatic longint get_dis(int ch);
    return longint'(dis_dly[ch*CNT_W +: CNT_W]);
  endfunction

  task automatic model_reset();
    for (int j = 0; j < NUM_CH; j++) begin
      m_mode[j] = M_OFF;
      m_t[j]    = 0;
    end
    m_done = '0;
    m_cyc  = 0;
    exp_q.delete();
  endtask

  task automatic model_step();
    bit release_ok;
    release_ok = 1'b1;
    if (LOCKSTEP)
      for (int j = 0; j < NUM_CH; j++)
        if (m_mode[j] == M_EN && req[j] && m_cyc < m_t[j]) release_ok = 1'b0;
    for (int j = 0; j < NUM_CH; j++) begin
      m_done[j] = 1'b0;
      case (m_mode[j])
        M_OFF: if (req[j]) begin
          m_mode[j] = M_EN;
          m_t[j]    = m_cyc + get_en(j) + 1;
        end
        M_EN: begin
          if (!req[j]) m_mode[j] = M_OFF;
          else if (m_cyc >= m_t[j] && release_ok) begin
            m_mode[j] = M_ON;
            m_done[j] = 1'b1;
          end
        end
        M_ON: if (!req[j]) begin
          m_mode[j] = M_DIS;
          m_t[j]    = m_cyc + get_dis(j) + 1;
        end
        default: if (m_cyc >= m_t[j]) begin
          m_mode[j] = M_OFF;
          m_done[j] = 1'b1;
        end
      endcase
    end
    m_cyc++;
  endtask

  function automatic logic [W-1:0] pack_exp();
    logic [NUM_CH-1:0]   e_chan, e_ssi, e_busy;
    logic [NUM_CH*2-1:0] e_state;
    for (int j = 0; j < NUM_CH; j++) begin
      e_chan[j]          = (m_mode[j] != M_OFF);
      e_ssi[j]           = (m_mode[j] == M_ON);
      e_busy[j]          = (m_mode[j] == M_EN) || (m_mode[j] == M_DIS);
      e_state[j*2 +: 2]  = 2'(m_mode[j]);
    end
    return {e_chan, e_ssi, e_busy, e_state, m_done};
  endfunction

  function automatic logic [W-1:0] obs_vec();
    return {chan_en, ssi_en, busy, state, done};
  endfunction

  // driver tasks
  task automatic set_en(int ch, int v);
    en_dly[ch*CNT_W +: CNT_W] = CNT_W'(v);
  endtask

  task automatic set_dis(int ch, int v);
    dis_dly[ch*CNT_W +: CNT_W] = CNT_W'(v);
  endtask

  task automatic drive_cycle();
    @(posedge clk);
    model_step();
    exp_q.push_back(pack_exp());
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    req = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    logic [W-1:0] exp_v;
    rst = 1'b1; req = '0; en_dly = '0; dis_dly = '0;
    #1;
    n_checks++;
    if (obs_vec() !== '0) begin
      n_errors++;
      $display("FAIL reset_hold got=%h exp=0", obs_vec());
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 100; i++) begin
      drive_cycle();
      exp_v = exp_q.pop_front();
      n_checks++;
      if (obs_vec() !== exp_v || obs_vec() !== '0) begin
        n_errors++;
        $display("FAIL reset_idle cyc=%0d got=%h exp=%h", i, obs_vec(), exp_v);
      end
    end
  endtask

  task automatic test_enable_ch0();
    logic [W-1:0] exp_v;
    int t_chan, t_ssi;
    apply_reset();
    set_en(0, 3);
    t_chan = -1; t_ssi = -1;
    req[0] = 1'b1;
    for (int i = 0; i < 20; i++) begin
      drive_cycle();
      exp_v = exp_q.pop_front();
      n_checks++;
      if (obs_vec() !== exp_v) begin
        n_errors++;
        $display("FAIL enable_model cyc=%0d got=%h exp=%h", i, obs_vec(), exp_v);
      end
      if (chan_en[0] === 1'b1 && t_chan < 0) t_chan = i;
      if (ssi_en[0] === 1'b1 && t_ssi < 0) begin
        t_ssi = i;
        n_checks++;
        if (done[0] !== 1'b1 || busy[0] !== 1'b0) begin
          n_errors++;
          $display("FAIL enable_done_busy got done=%b busy=%b exp done=1 busy=0", done[0], busy[0]);
        end
      end else if (t_ssi >= 0 && i == t_ssi + 1) begin
        n_checks++;
        if (done[0] !== 1'b0 || busy[0] !== 1'b0) begin
          n_errors++;
          $display("FAIL enable_after got done=%b busy=%b exp done=0 busy=0", done[0], busy[0]);
        end
      end
    end
    n_checks++;
    if (t_chan != 0) begin
      n_errors++;
      $display("FAIL enable_chan_rise got=%0d exp=0", t_chan);
    end
    n_checks++;
    if (t_ssi < 0 || t_ssi - t_chan != 4) begin
      n_errors++;
      $display("FAIL enable_ssi_delay got=%0d exp=4", t_ssi - t_chan);
    end
  endtask

  task automatic test_disable_ch1();
    logic [W-1:0] exp_v;
    apply_reset();
    set_en(1, 0);
    set_dis(1, 0);
    req[1] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive_cycle();
      exp_v = exp_q.pop_front();
      n_checks++;
      if (obs_vec() !== exp_v) begin
        n_errors++;
        $display("FAIL disable_model_up cyc=%0d got=%h exp=%h", i, obs_vec(), exp_v);
      end
      if (ssi_en[1] === 1'b1) break;
    end
    n_checks++;
    if (ssi_en[1] !== 1'b1) begin
      n_errors++;
      $display("FAIL disable_reach_on got ssi_en=%b exp=1 within 10 cycles", ssi_en[1]);
    end
    req[1] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_cycle();
      exp_v = exp_q.pop_front();
      n_checks++;
      if (obs_vec() !== exp_v) begin
        n_errors++;
        $display("FAIL disable_model_down cyc=%0d got=%h exp=%h", i, obs_vec(), exp_v);
      end
      n_checks++;
      if (i == 0 && (ssi_en[1] !== 1'b0 || chan_en[1] !== 1'b1 || state[3:2] !== 2'b11)) begin
        n_errors++;
        $display("FAIL disable_step0 got ssi=%b chan=%b st=%b exp ssi=0 chan=1 st=11", ssi_en[1], chan_en[1], state[3:2]);
      end else if (i == 1 && (chan_en[1] !== 1'b0 || done[1] !== 1'b1)) begin
        n_errors++;
        $display("FAIL disable_step1 got chan=%b done=%b exp chan=0 done=1", chan_en[1], done[1]);
      end else if (i == 2 && done[1] !== 1'b0) begin
        n_errors++;
        $display("FAIL disable_step2 got done=%b exp=0", done[1]);
      end
    end
  endtask

  task automatic test_abort_ch2();
    logic [W-1:0] exp_v;
    bit seen;
    apply_reset();
    set_en(2, 10);
    seen = 1'b0;
    req[2] = 1'b1;
    for (int i = 0; i < 21; i++) begin
      if (i == 5) req[2] = 1'b0;
      drive_cycle();
      exp_v = exp_q.pop_front();
      n_checks++;
      if (obs_vec() !== exp_v) begin
        n_errors++;
        $display("FAIL abort_model cyc=%0d got=%h exp=%h", i, obs_vec(), exp_v);
      end
      if (ssi_en[2] !== 1'b0 || done[2] !== 1'b0) seen = 1'b1;
      if (i == 5) begin
        n_checks++;
        if (state[5:4] !== 2'b00 || chan_en[2] !== 1'b0) begin
          n_errors++;
          $display("FAIL abort_off got st=%b chan=%b exp st=00 chan=0", state[5:4], chan_en[2]);
        end
      end
    end
    n_checks++;
    if (seen) begin
      n_errors++;
      $display("FAIL abort_no_ssi_done got seen=1 exp=0");
    end
  endtask

  task automatic test_dis_retrigger_ch3();
    logic [W-1:0] exp_v;
    logic [1:0] seq[8];
    int n_dis, n_off;
    apply_reset();
    set_en(3, 1);
    set_dis(3, 4);
    req[3] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive_cycle();
      exp_v = exp_q.pop_front();
      n_checks++;
      if (obs_vec() !== exp_v) begin
        n_errors++;
        $display("FAIL retrig_model_up cyc=%0d got=%h exp=%h", i, obs_vec(), exp_v);
      end
      if (ssi_en[3] === 1'b1) break;
    end
    req[3] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      drive_cycle();
      req[3] = 1'b1;
      exp_v = exp_q.pop_front();
      seq[i] = state[7:6];
      n_checks++;
      if (obs_vec() !== exp_v) begin
        n_errors++;
        $display("FAIL retrig_model cyc=%0d got=%h exp=%h", i, obs_vec(), exp_v);
      end
      n_checks++;
      if ((ssi_en & ~chan_en) !== '0) begin
        n_errors++;
        $display("FAIL retrig_invariant cyc=%0d ssi=%b chan=%b", i, ssi_en, chan_en);
      end
    end
    n_dis = 0; n_off = 0;
    for (int i = 0; i < 8; i++) begin
      if (seq[i] == 2'b11) n_dis++;
      if (seq[i] == 2'b00) n_off++;
    end
    n_checks++;
    if (n_dis != 5 || n_off != 1 || seq[6] !== 2'b01) begin
      n_errors++;
      $display("FAIL retrig_seq got dis=%0d off=%0d st6=%b exp dis=5 off=1 st6=01", n_dis, n_off, seq[6]);
    end
  endtask

  task automatic test_lockstep();
    logic [W-1:0] exp_v;
    int t_chan, t_ssi0, t_ssi1, exp0;
    apply_reset();
    set_en(0, 2);
    set_en(1, 7);
    t_chan = -1; t_ssi0 = -1; t_ssi1 = -1;
    exp0 = LOCKSTEP ? 8 : 3;
    req[1:0] = 2'b11;
    for (int i = 0; i < 20; i++) begin
      drive_cycle();
      exp_v = exp_q.pop_front();
      n_checks++;
      if (obs_vec() !== exp_v) begin
        n_errors++;
        $display("FAIL lockstep_model cyc=%0d got=%h exp=%h", i, obs_vec(), exp_v);
      end
      if (chan_en[0] === 1'b1 && t_chan < 0) t_chan = i;
      if (ssi_en[0] === 1'b1 && t_ssi0 < 0) t_ssi0 = i;
      if (ssi_en[1] === 1'b1 && t_ssi1 < 0) t_ssi1 = i;
    end
    n_checks++;
    if (t_ssi1 < 0 || t_ssi1 - t_chan != 8) begin
      n_errors++;
      $display("FAIL lockstep_ch1_delay got=%0d exp=8", t_ssi1 - t_chan);
    end
    n_checks++;
    if (t_ssi0 < 0 || t_ssi0 - t_chan != exp0) begin
      n_errors++;
      $display("FAIL lockstep_ch0_delay got=%0d exp=%0d", t_ssi0 - t_chan, exp0);
    end
    // asynchronous reset in the middle of EN_WAIT
    apply_reset();
    req[1:0] = 2'b11;
    for (int i = 0; i < 2; i++) begin
      drive_cycle();
      exp_v = exp_q.pop_front();
      n_checks++;
      if (obs_vec() !== exp_v) begin
        n_errors++;
        $display("FAIL midreset_model cyc=%0d got=%h exp=%h", i, obs_vec(), exp_v);
      end
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (obs_vec() !== '0) begin
      n_errors++;
      $display("FAIL midreset_clear got=%h exp=0", obs_vec());
    end
    @(negedge clk);
    rst = 1'b0;
    req = '0;
    model_reset();
  endtask

  task automatic test_random();
    logic [W-1:0] exp_v;
    apply_reset();
    for (int j = 0; j < NUM_CH; j++) begin
      set_en(j, $urandom_range(0, 6));
      set_dis(j, $urandom_range(0, 6));
    end
    for (int i = 0; i < 1500; i++) begin
      for (int j = 0; j < NUM_CH; j++) begin
        if ($urandom_range(0, 7) == 0) req[j] = ~req[j];
        if ($urandom_range(0, 15) == 0) set_en(j, $urandom_range(0, 6));
        if ($urandom_range(0, 15) == 0) set_dis(j, $urandom_range(0, 6));
      end
      drive_cycle();
      exp_v = exp_q.pop_front();
      n_checks++;
      if (obs_vec() !== exp_v) begin
        n_errors++;
        $display("FAIL random_model cyc=%0d got=%h exp=%h", i, obs_vec(), exp_v);
      end
      n_checks++;
      if ((ssi_en & ~chan_en) !== '0) begin
        n_errors++;
        $display("FAIL random_invariant cyc=%0d ssi=%b chan=%b", i, ssi_en, chan_en);
      end
    end
  endtask

  initial begin
    test_reset();
    test_enable_ch0();
    test_disable_ch1();
    test_abort_ch2();
    test_dis_retrigger_ch3();
    test_lockstep();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
